dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
- Memory-stage data-memory access controller for the 5-stage MIPS pipeline.
- Decodes the M-stage load/store and checks alignment.
- Drives a request/acknowledge data-memory port with store byte-lane steering, and stalls the pipeline until the access completes.
- Owns the M/W pipeline register that supplies raw word Din_W, IR_W and OFFSET to the W-stage load-extension unit.

Parameters:
- ACK_TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before a bus error is taken.
- CNT_W, 8, width of timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_M  in  1  M stage holds a real instruction; 0 = bubble.
- IR_M  in  32  M-stage instruction.
- ADDR_M  in  32  ALU result: effective address for loads/stores, pass-through result otherwise.
- WD_M  in  32  store data (forwarded rt).
- mem_req  out  1  access request; held until ack.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_addr  out  32  word address, {ADDR_M[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  read word; valid with mem_ack.
- stall  out  1  freezes F/D/E/M stages.
- Din_W  out  32  to W stage: raw memory word for loads, ADDR_M otherwise.
- IR_W  out  32  W-stage instruction.
- OFFSET  out  2  ADDR_M[1:0] registered.
- adel_W  out  1  load address error.
- ades_W  out  1  store address error.
- buserr_W  out  1  access timed out.

Behaviour:
- Opcodes (IR_M[31:26]):
  - Loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Every other opcode is a non-memory op.
- Alignment: halfword ops need ADDR_M[0]=0; word ops need ADDR_M[1:0]=0; byte ops are always aligned.
  - A misaligned op issues no request and raises no stall.
  - It advances to W with adel_W (load) or ades_W (store) =1.
- Store lane steering:
  - sb: be=4'b0001<<ADDR_M[1:0], wdata={4{WD_M[7:0]}}.
  - sh: be=ADDR_M[1]?4'b1100:4'b0011, wdata={2{WD_M[15:0]}}.
  - sw: be=4'b1111, wdata=WD_M.
  - Loads: we=0, be=4'b1111.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if valid_M and the op is an aligned memory op, stall=1 combinationally. Register addr/we/be/wdata, clear the counter, go to REQ. Otherwise stall=0.
  - REQ: mem_req=1; all request outputs stay stable; stall=1.
    - mem_ack=1: capture mem_rdata into rdbuf, go to DONE.
    - No ack: counter+1. When counter==ACK_TIMEOUT with no ack, set buserr latch, drop mem_req, go to DONE.
  - DONE: stall=0 for exactly one cycle, so M/W captures the op; then go to IDLE.
- Minimum memory-op latency is 3 cycles (2 stalled): ack arrives in the first REQ cycle.
- mem_req is deasserted the cycle after ack is sampled, i.e. in DONE.
- mem_ack outside REQ is ignored; no state change.
- M/W register, every clock edge:
  - stall=0, valid_M=1: IR_W<=IR_M; OFFSET<=ADDR_M[1:0]; Din_W<= (aligned load ? rdbuf : ADDR_M).
    - Aligned stores: Din_W<=ADDR_M.
    - adel/ades/buserr take their current values.
  - stall=0, valid_M=0: insert a bubble. IR_W=0 and all W outputs =0.
  - stall=1: insert a bubble, so the stalled op is never written back twice.
- buserr latch clears when the op leaves in DONE.
- Reset (async, low):
  - FSM=IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Counter=0; rdbuf=0.
  - IR_W=0, Din_W=0, OFFSET=0; all error flags 0.
  - stall=0 while in reset.
  - Reset mid-REQ drops mem_req immediately; the in-flight access is abandoned; a later ack is ignored.
- Back-to-back memory ops: IDLE accepts the next op in the cycle after DONE; no idle gap is required beyond that.

Decomposition:
- Shared package mips_pkg:
  - Opcode localparams for lb/lh/lw/lbu/lhu/sb/sh/sw.
  - FSM state encoding.
  - is_load/is_store/needs_half_align/needs_word_align functions.
- One combinational sub-module, dm_lane_steer: in op, ADDR_M[1:0], WD_M; out we, be, wdata, misaligned.

Test Plan:
- sw, ADDR_M=0x00000104, WD_M=0xDEADBEEF, ack on first REQ cycle → mem_addr=0x104, be=1111, wdata=0xDEADBEEF. stall high 2 cycles; IR_W=sw on the 3rd edge.
- sb to 0x107, WD_M=0x000000A5 → be=1000, wdata=0xA5A5A5A5. sh to 0x106, WD_M=0x1234 → be=1100, wdata=0x12341234.
- lb from 0x10D, mem_rdata=0x80FF7F01, ack after 4 wait cycles → stall held 6 cycles total. Din_W=0x80FF7F01, OFFSET=01; the downstream extender yields 0x0000007F.
- lh at 0x103 and lw at 0x102 → no mem_req, no stall; adel_W=1, IR_W=the op, next cycle. sw at 0x101 → ades_W=1.
- No ack, ACK_TIMEOUT=4 → mem_req high exactly 5 cycles then drops; buserr_W=1 on the op reaching W.
- reset low in the 2nd REQ cycle → mem_req=0 asynchronously; IR_W=0. An ack pulse one cycle after release leaves the FSM in IDLE with stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: memory opcodes, access FSM states and opcode classification helpers.
package mips_pkg;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} dm_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic needs_half_align(input logic [5:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic needs_word_align(input logic [5:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction
endpackage

// File: rtl/dm_lane_steer.sv
// dm_lane_steer: store byte-lane enables, replicated write data and alignment check.
module dm_lane_steer
    import mips_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);
    always_comb begin
        we_o         = is_store(op_i);
        be_o         = op_i == OP_SB ? 4'b0001 << addr_lo_i
                     : op_i == OP_SH ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o      = op_i == OP_SB ? {4{wd_i[7:0]}} : op_i == OP_SH ? {2{wd_i[15:0]}} : wd_i;
        misaligned_o = (needs_half_align(op_i) && addr_lo_i[0])
                     || (needs_word_align(op_i) && addr_lo_i != 2'b00);
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: M-stage data-memory request/ack controller with stall and M/W pipeline register.
module dm_access_ctrl
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_M,
    input  logic [31:0] IR_M,
    input  logic [31:0] ADDR_M,
    input  logic [31:0] WD_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] Din_W,
    output logic [31:0] IR_W,
    output logic [1:0]  OFFSET,
    output logic        adel_W,
    output logic        ades_W,
    output logic        buserr_W
);
    logic [5:0] op;
    logic ld, st, mis, go, busy, st_we;
    logic [3:0] st_be;
    logic [31:0] st_wdata;
    dm_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic buserr_q, buserr_d;
    logic [31:0] rdbuf_q, rdbuf_d;
    logic we_q;
    logic [3:0] be_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] ir_w_q, din_w_q;
    logic [1:0] off_q;
    logic adel_q, ades_q, berr_w_q;

    assign op = IR_M[31:26];
    assign ld = valid_M && is_load(op);
    assign st = valid_M && is_store(op);
    assign go = (ld || st) && !mis;

    dm_lane_steer u_steer (
        .op_i         (op),
        .addr_lo_i    (ADDR_M[1:0]),
        .wd_i         (WD_M),
        .we_o         (st_we),
        .be_o         (st_be),
        .wdata_o      (st_wdata),
        .misaligned_o (mis)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buserr_d = buserr_q;
        rdbuf_d  = rdbuf_q;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = go;
                if (go) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (mem_ack) begin
                    rdbuf_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                buserr_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall     = reset && busy;
    assign mem_req   = state_q == ST_REQ;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            buserr_q <= 1'b0;
            rdbuf_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
            rdbuf_q  <= rdbuf_d;
            if (state_q == ST_IDLE && go) begin
                we_q    <= st_we;
                be_q    <= st_be;
                addr_q  <= {ADDR_M[31:2], 2'b00};
                wdata_q <= st_wdata;
            end
        end
    end

    // Stalled cycles write a bubble so a held op reaches W only once, on its DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || !valid_M || stall) begin
            ir_w_q   <= '0;
            din_w_q  <= '0;
            off_q    <= '0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            berr_w_q <= 1'b0;
        end else begin
            ir_w_q   <= IR_M;
            din_w_q  <= (ld && !mis) ? rdbuf_q : ADDR_M;
            off_q    <= ADDR_M[1:0];
            adel_q   <= ld && mis;
            ades_q   <= st && mis;
            berr_w_q <= buserr_q;
        end
    end

    assign IR_W     = ir_w_q;
    assign Din_W    = din_w_q;
    assign OFFSET   = off_q;
    assign adel_W   = adel_q;
    assign ades_W   = ades_q;
    assign buserr_W = berr_w_q;
endmodule
